// File: rtl/fir_stream_seq.sv
// fir_stream_seq: run controller for the FIR stream path.
// Ports: wb_clk_i/wb_rst_n clock and async active-low reset; wbs_* Wishbone
//   slave for ap_ctrl (0x00), data_len (0x10), status (0x14), timeout (0x18);
//   s_ss_* stream in from the input bridge, m_ss_* gated stream to the FIR;
//   sm_tvalid/sm_tready monitor of FIR output handshakes; irq_o level irq.
module fir_stream_seq #(
    parameter int pDATA_WIDTH = 32,
    parameter int pCNT_WIDTH  = 16,
    parameter int pTO_WIDTH   = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic                   s_ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_ss_tdata,
    input  logic                   s_ss_tlast,
    output logic                   s_ss_tready,
    output logic                   m_ss_tvalid,
    output logic [pDATA_WIDTH-1:0] m_ss_tdata,
    output logic                   m_ss_tlast,
    input  logic                   m_ss_tready,
    input  logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic                   irq_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [pCNT_WIDTH-1:0] CNT_ONE = {{(pCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pCNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [pTO_WIDTH-1:0]  TO_ONE  = {{(pTO_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pTO_WIDTH-1:0]  TO_MAX  = '1;

    state_t state, state_nx;

    logic [pCNT_WIDTH-1:0] data_len, in_cnt, out_cnt, in_nx, out_nx;
    logic [pTO_WIDTH-1:0]  timeout, stall_cnt, stall_nx;
    logic                  ap_start, ap_done, err, irq_en, ap_idle;
    logic                  sel_ctrl, sel_len, sel_stat, sel_to;
    logic                  hit, req, wr, rd, ctrl_rd, start_wr, len0;
    logic                  admit, active, in_hs, out_hs, in_last, fin;
    logic                  expire, done_set;
    logic [31:0]           rdata;
    logic                  unused_ok;

    assign unused_ok = ^{wbs_sel_i, s_ss_tlast, wbs_adr_i[23:8], wbs_dat_i};

    // Address decode; ack is suppressed the cycle after an ack so that a
    // held strobe is served every other cycle.
    assign sel_ctrl = wbs_adr_i[7:0] == 8'h00;
    assign sel_len  = wbs_adr_i[7:0] == 8'h10;
    assign sel_stat = wbs_adr_i[7:0] == 8'h14;
    assign sel_to   = wbs_adr_i[7:0] == 8'h18;
    assign hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == 8'h30)
               & (sel_ctrl | sel_len | sel_stat | sel_to);
    assign req      = hit & ~wbs_ack_o;
    assign wr       = req & wbs_we_i;
    assign rd       = req & ~wbs_we_i;
    assign ctrl_rd  = rd & sel_ctrl;
    assign start_wr = wr & sel_ctrl & wbs_dat_i[0] & (state == IDLE);
    assign len0     = data_len == '0;
    assign ap_idle  = (state == IDLE) | (state == DONE);

    // Stream gating
    assign admit       = state == RUN;
    assign active      = admit | (state == DRAIN);
    assign m_ss_tvalid = s_ss_tvalid & admit;
    assign s_ss_tready = m_ss_tready & admit;
    assign m_ss_tdata  = s_ss_tdata;
    assign m_ss_tlast  = admit & (in_cnt == data_len - CNT_ONE);

    assign in_hs  = m_ss_tvalid & m_ss_tready;
    assign out_hs = sm_tvalid & sm_tready & active;
    assign in_nx  = (in_cnt == CNT_MAX) ? in_cnt : in_cnt + CNT_ONE;
    assign out_nx = (out_cnt == CNT_MAX) ? out_cnt : out_cnt + CNT_ONE;
    assign in_last = in_hs & (in_nx == data_len);
    assign fin     = (out_hs ? out_nx : out_cnt) == data_len;

    // A handshake in the same cycle blocks expiry, so completion wins.
    assign stall_nx = (stall_cnt == TO_MAX) ? stall_cnt : stall_cnt + TO_ONE;
    assign expire = active & ~in_hs & ~out_hs & (timeout != '0)
                  & (stall_nx == timeout);

    always_comb begin
        state_nx = state;
        done_set = 1'b0;
        unique case (state)
            IDLE:  if (start_wr) state_nx = len0 ? DONE : RUN;
            RUN: begin
                if (in_last)     state_nx = fin ? DONE : DRAIN;
                else if (expire) state_nx = DONE;
            end
            DRAIN: if (fin || expire) state_nx = DONE;
            DONE:  if (ctrl_rd) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        done_set = (state != DONE) && (state_nx == DONE);
        // Done landing on a status read is consumed by that read.
        if (done_set && ctrl_rd) state_nx = IDLE;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_ctrl: rdata = {27'd0, irq_en, err | expire, ap_idle,
                               ap_done | done_set, ap_start};
            sel_len:  rdata = 32'(data_len);
            sel_stat: rdata = {16'(out_cnt), 16'(in_cnt)};
            sel_to:   rdata = 32'(timeout);
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            data_len  <= '0;
            timeout   <= '0;
            irq_en    <= 1'b0;
            ap_start  <= 1'b0;
            ap_done   <= 1'b0;
            err       <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd ? rdata : '0;
            if (wr && sel_len && ap_idle) data_len <= wbs_dat_i[pCNT_WIDTH-1:0];
            if (wr && sel_to)   timeout <= wbs_dat_i[pTO_WIDTH-1:0];
            if (wr && sel_ctrl) irq_en  <= wbs_dat_i[4];

            if (start_wr && !len0)        ap_start <= 1'b1;
            else if (in_hs || !admit)     ap_start <= 1'b0;

            if (ctrl_rd)       ap_done <= 1'b0;
            else if (done_set) ap_done <= 1'b1;
            else if (start_wr) ap_done <= 1'b0;

            if (start_wr)    err <= 1'b0;
            else if (expire) err <= 1'b1;

            if (start_wr)   in_cnt <= '0;
            else if (in_hs) in_cnt <= in_nx;

            if (start_wr)    out_cnt <= '0;
            else if (out_hs) out_cnt <= out_nx;

            if (state_nx != state || in_hs || out_hs || !active)
                stall_cnt <= '0;
            else
                stall_cnt <= stall_nx;
        end
    end

    assign irq_o = irq_en & ap_done;

endmodule

// File: tb/tb_fir_stream_seq.sv
// tb_fir_stream_seq: randomized self-checking bench for fir_stream_seq.
// Drives Wishbone and stream ports, compares against a sample-queue model.
module tb_fir_stream_seq;

    localparam logic [31:0] CTRL = 32'h3000_0000;
    localparam logic [31:0] LEN  = 32'h3000_0010;
    localparam logic [31:0] STAT = 32'h3000_0014;
    localparam logic [31:0] TO   = 32'h3000_0018;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        s_ss_tvalid, s_ss_tlast, s_ss_tready;
    logic [31:0] s_ss_tdata;
    logic        m_ss_tvalid, m_ss_tlast, m_ss_tready;
    logic [31:0] m_ss_tdata;
    logic        sm_tvalid, sm_tready;
    logic        irq_o;

    int n_checks;
    int n_pass;
    logic [31:0] src [0:63];

    always #5 wb_clk_i = ~wb_clk_i;

    fir_stream_seq dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n    (wb_rst_n),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .s_ss_tvalid (s_ss_tvalid),
        .s_ss_tdata  (s_ss_tdata),
        .s_ss_tlast  (s_ss_tlast),
        .s_ss_tready (s_ss_tready),
        .m_ss_tvalid (m_ss_tvalid),
        .m_ss_tdata  (m_ss_tdata),
        .m_ss_tlast  (m_ss_tlast),
        .m_ss_tready (m_ss_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tready   (sm_tready),
        .irq_o       (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] outs();
        return {26'd0, wbs_ack_o, s_ss_tready, m_ss_tvalid, m_ss_tlast,
                irq_o, wbs_dat_o != 32'd0};
    endfunction

    task automatic stream_idle();
        s_ss_tvalid = 1'b0;
        s_ss_tlast  = 1'b0;
        s_ss_tdata  = '0;
        m_ss_tready = 1'b0;
        sm_tvalid   = 1'b0;
        sm_tready   = 1'b0;
    endtask

    task automatic wb_access(input logic [31:0] adr, input logic we,
                             input logic [31:0] dat, output logic [31:0] rd);
        int t;
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        t = 0;
        do begin
            @(posedge wb_clk_i); #1;
            t++;
        end while (!wbs_ack_o && t < 8);
        check("wb_ack", 32'(wbs_ack_o), 32'd1);
        rd = wbs_dat_o;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        wb_access(adr, 1'b1, dat, d);
        check("wr_dat_zero", d, 32'd0);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
        wb_access(adr, 1'b0, 32'd0, d);
    endtask

    // Model: the run admits exactly n samples in order; the FIR returns one
    // output per admitted sample; mode 1 toggles m_ss_tready with valid held.
    task automatic run_stream(input int n, input int mode);
        int in_m, out_m, cyc;
        in_m = 0;
        out_m = 0;
        cyc = 0;
        for (int i = 0; i < n; i++) src[i] = $urandom;
        while (out_m < n && cyc < 3000) begin
            @(posedge wb_clk_i); #1;
            cyc++;
            if (mode == 1) begin
                s_ss_tvalid = 1'b1;
                m_ss_tready = (cyc % 2 == 1);
                sm_tready   = 1'b1;
            end else begin
                s_ss_tvalid = ($urandom_range(0, 3) != 0);
                m_ss_tready = ($urandom_range(0, 3) != 0);
                sm_tready   = ($urandom_range(0, 3) != 0);
            end
            s_ss_tdata = (in_m < n) ? src[in_m] : $urandom;
            s_ss_tlast = 1'($urandom);
            sm_tvalid  = (out_m < in_m) && ($urandom_range(0, 2) != 0);
            @(negedge wb_clk_i);
            check("gate", 32'({m_ss_tvalid, s_ss_tready}),
                  32'({s_ss_tvalid && in_m < n, m_ss_tready && in_m < n}));
            if (m_ss_tvalid && m_ss_tready) begin
                check("tdata", m_ss_tdata, src[in_m]);
                check("tlast", 32'(m_ss_tlast), 32'(in_m == n - 1));
                in_m++;
            end
            if (sm_tvalid && sm_tready) out_m++;
        end
        check("stream_outputs", 32'(out_m), 32'(n));
        @(posedge wb_clk_i); #1;
        stream_idle();
    endtask

    task automatic finish_run(input int n, input logic ie);
        logic [31:0] d;
        check("irq_done", 32'(irq_o), 32'(ie));
        wb_read(STAT, d);
        check("status", d, {16'(n), 16'(n)});
        wb_read(CTRL, d);
        check("ctrl_done", d, {27'd0, ie, 4'b0110});
        wb_read(CTRL, d);
        check("ctrl_idle", d, {27'd0, ie, 4'b0100});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int acks;
        int n;
        logic ie;

        n_checks = 0;
        n_pass = 0;
        wb_rst_n = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i = 1'b0;
        wbs_sel_i = 4'hf;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        stream_idle();
        s_ss_tvalid = 1'b1;
        m_ss_tready = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_outs", outs(), 32'd0);
        stream_idle();
        wb_rst_n = 1'b1;

        wb_read(CTRL, d);
        check("rst_ctrl", d, 32'h4);
        wb_read(LEN, d);
        check("rst_len", d, 32'd0);
        wb_read(TO, d);
        check("rst_to", d, 32'd0);
        wb_read(STAT, d);
        check("rst_stat", d, 32'd0);

        // Undecoded offset is never acked.
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_adr_i = 32'h3000_0004;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            acks += int'(wbs_ack_o);
        end
        check("undecoded_ack", 32'(acks), 32'd0);

        // Held strobe: ack every other cycle.
        wbs_adr_i = LEN;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            acks += int'(wbs_ack_o);
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        check("b2b_acks", 32'(acks), 32'd2);

        s_ss_tvalid = 1'b1;
        m_ss_tready = 1'b1;
        @(negedge wb_clk_i);
        check("idle_gate", 32'({m_ss_tvalid, s_ss_tready}), 32'd0);
        stream_idle();

        // Nominal run of 11.
        wb_write(LEN, 32'd11);
        wb_write(CTRL, 32'h1);
        run_stream(11, 0);
        finish_run(11, 1'b0);

        // Random runs.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 20);
            ie = 1'($urandom);
            wb_write(LEN, 32'(n));
            wb_read(LEN, d);
            check("len_rb", d, 32'(n));
            wb_write(CTRL, {27'd0, ie, 4'b0001});
            run_stream(n, 0);
            finish_run(n, ie);
        end

        // Backpressure.
        wb_write(LEN, 32'd5);
        wb_write(CTRL, 32'h1);
        run_stream(5, 1);
        finish_run(5, 1'b0);

        // Zero length.
        wb_write(LEN, 32'd0);
        wb_write(CTRL, 32'h11);
        check("zl_irq", 32'(irq_o), 32'd1);
        s_ss_tvalid = 1'b1;
        m_ss_tready = 1'b1;
        @(negedge wb_clk_i);
        check("zl_gate", 32'({m_ss_tvalid, s_ss_tready}), 32'd0);
        stream_idle();
        wb_read(CTRL, d);
        check("zl_ctrl_done", d, 32'h16);
        wb_read(CTRL, d);
        check("zl_ctrl_idle", d, 32'h14);
        wb_read(STAT, d);
        check("zl_stat", d, 32'd0);
        wb_write(CTRL, 32'h0);

        // data_len write ignored while running.
        wb_write(LEN, 32'd6);
        wb_write(CTRL, 32'h1);
        wb_read(CTRL, d);
        check("run_ctrl", d, 32'h1);
        wb_write(LEN, 32'd9);
        wb_read(LEN, d);
        check("len_locked", d, 32'd6);
        run_stream(6, 0);
        finish_run(6, 1'b0);

        // Timeout after 3 of 8 samples.
        wb_write(TO, 32'd20);
        wb_read(TO, d);
        check("to_rb", d, 32'd20);
        wb_write(LEN, 32'd8);
        wb_write(CTRL, 32'h11);
        s_ss_tvalid = 1'b1;
        m_ss_tready = 1'b1;
        s_ss_tdata = $urandom;
        repeat (3) @(posedge wb_clk_i);
        #1;
        s_ss_tvalid = 1'b0;
        repeat (19) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("to_early", 32'(irq_o), 32'd0);
        @(negedge wb_clk_i);
        check("to_irq", 32'(irq_o), 32'd1);
        stream_idle();
        wb_read(STAT, d);
        check("to_stat", d, 32'h3);
        wb_read(CTRL, d);
        check("to_ctrl_done", d, 32'h1e);
        wb_read(CTRL, d);
        check("to_ctrl_idle", d, 32'h1c);
        wb_write(TO, 32'd0);

        // Async reset mid-DRAIN with a read ack in flight.
        wb_write(LEN, 32'd4);
        wb_write(CTRL, 32'h1);
        s_ss_tvalid = 1'b1;
        m_ss_tready = 1'b1;
        s_ss_tdata = $urandom;
        repeat (4) @(posedge wb_clk_i);
        #1;
        @(negedge wb_clk_i);
        check("drain_gate", 32'({m_ss_tvalid, s_ss_tready}), 32'd0);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i = 1'b0;
        wbs_adr_i = STAT;
        @(posedge wb_clk_i); #1;
        check("drain_ack", 32'(wbs_ack_o), 32'd1);
        check("drain_stat", wbs_dat_o, 32'h4);
        #2;
        wb_rst_n = 1'b0;
        #1;
        check("mid_rst_outs", outs(), 32'd0);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        stream_idle();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        wb_read(CTRL, d);
        check("post_rst_ctrl", d, 32'h4);
        wb_read(LEN, d);
        check("post_rst_len", d, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
